// File: rtl/draw_player.sv
// rtl/draw_player.sv - overlays a walking/jumping player rectangle on a VGA stream, 2-cycle latency
// Optional build macro PLAYER_OUTLINE_EN: draw the rectangle's outer 1-px border black.
module draw_player #(
    parameter int          PLAYER_W   = 32,
    parameter int          PLAYER_H   = 48,
    parameter int          X_INIT     = 100,
    parameter int          GROUND_Y   = 500,
    parameter int          STEP       = 4,
    parameter int          JUMP_V0    = 12,
    parameter int          GRAVITY    = 1,
    parameter int          V_MAX      = 15,
    parameter int          HOR_PIXELS = 1024,
    parameter logic [11:0] PLAYER_RGB = 12'hF80
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        move_left,
    input  logic        move_right,
    input  logic        jump,
    input  logic [10:0] vga_in_hcount,
    input  logic [10:0] vga_in_vcount,
    input  logic        vga_in_hsync,
    input  logic        vga_in_vsync,
    input  logic        vga_in_hblnk,
    input  logic        vga_in_vblnk,
    input  logic [11:0] vga_in_rgb,
    output logic [10:0] vga_out_hcount,
    output logic [10:0] vga_out_vcount,
    output logic        vga_out_hsync,
    output logic        vga_out_vsync,
    output logic        vga_out_hblnk,
    output logic        vga_out_vblnk,
    output logic [11:0] vga_out_rgb
);

    typedef enum logic [1:0] {GROUND = 2'd0, RISE = 2'd1, FALL = 2'd2} state_t;

    localparam logic [10:0] X_SPAWN  = 11'(X_INIT);
    localparam logic [10:0] Y_SPAWN  = 11'(GROUND_Y - PLAYER_H + 1);
    localparam logic [11:0] Y_SPAWN_W = 12'(GROUND_Y - PLAYER_H + 1);
    localparam logic [11:0] X_MIN    = 12'd1;
    localparam logic [11:0] X_MAX    = 12'(HOR_PIXELS - 1 - PLAYER_W);
    localparam logic [11:0] STEP_W   = 12'(STEP);
    localparam logic [11:0] PW_M1    = 12'(PLAYER_W - 1);
    localparam logic [11:0] PH_M1    = 12'(PLAYER_H - 1);
    localparam logic [5:0]  VY0      = 6'(JUMP_V0);
    localparam logic [5:0]  GRAV     = 6'(GRAVITY);
    localparam logic [5:0]  VMAX     = 6'(V_MAX);

    logic        vblnk_prev_q;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic [5:0]  vy_q, vy_d;
    state_t      state_q, state_d;

    logic        tick;
    logic [11:0] x_w, y_w, y_sum;

    assign tick  = vga_in_vblnk & ~vblnk_prev_q;
    assign x_w   = {1'b0, x_q};
    assign y_w   = {1'b0, y_q};
    assign y_sum = y_w + {6'd0, vy_q};

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        vy_d    = vy_q;
        state_d = state_q;
        if (tick) begin
            if (move_left && !move_right) begin
                x_d = (x_w >= X_MIN + STEP_W) ? x_q - STEP_W[10:0] : X_MIN[10:0];
            end else if (move_right && !move_left) begin
                x_d = (x_w + STEP_W <= X_MAX) ? x_q + STEP_W[10:0] : X_MAX[10:0];
            end
            case (state_q)
                GROUND: begin
                    if (jump) begin
                        vy_d    = VY0;
                        state_d = RISE;
                    end
                end
                RISE: begin
                    y_d = (y_q >= {5'd0, vy_q}) ? y_q - {5'd0, vy_q} : 11'd0;
                    if (vy_q <= GRAV) begin
                        vy_d    = 6'd0;
                        state_d = FALL;
                    end else begin
                        vy_d = vy_q - GRAV;
                    end
                end
                FALL: begin
                    if (y_sum >= Y_SPAWN_W) begin
                        y_d     = Y_SPAWN;
                        vy_d    = 6'd0;
                        state_d = GROUND;
                    end else begin
                        y_d  = y_sum[10:0];
                        vy_d = (vy_q + GRAV >= VMAX) ? VMAX : vy_q + GRAV;
                    end
                end
                default: state_d = GROUND;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_prev_q <= 1'b0;
            x_q          <= X_SPAWN;
            y_q          <= Y_SPAWN;
            vy_q         <= 6'd0;
            state_q      <= GROUND;
        end else begin
            vblnk_prev_q <= vga_in_vblnk;
            x_q          <= x_d;
            y_q          <= y_d;
            vy_q         <= vy_d;
            state_q      <= state_d;
        end
    end

    // Stage 1: register the pixel and decide whether it lies inside the player
    logic [11:0] h_w, v_w;
    logic        inside_c;
    assign h_w      = {1'b0, vga_in_hcount};
    assign v_w      = {1'b0, vga_in_vcount};
    assign inside_c = (h_w >= x_w) && (h_w <= x_w + PW_M1) &&
                      (v_w >= y_w) && (v_w <= y_w + PH_M1);

    logic [10:0] s1_hcount_q, s1_vcount_q;
    logic        s1_hsync_q, s1_vsync_q, s1_hblnk_q, s1_vblnk_q, s1_inside_q;
    logic [11:0] s1_rgb_q;
    logic [11:0] fill_rgb;

`ifdef PLAYER_OUTLINE_EN
    logic border_c, s1_border_q;
    assign border_c = inside_c && ((h_w == x_w) || (h_w == x_w + PW_M1) ||
                                   (v_w == y_w) || (v_w == y_w + PH_M1));
    always_ff @(posedge clk) begin
        if (rst) s1_border_q <= 1'b0;
        else     s1_border_q <= border_c;
    end
    assign fill_rgb = s1_border_q ? 12'h000 : PLAYER_RGB;
`else
    assign fill_rgb = PLAYER_RGB;
`endif

    logic [11:0] rgb_d;
    always_comb begin
        rgb_d = s1_rgb_q;
        if (s1_hblnk_q || s1_vblnk_q) rgb_d = 12'h000;
        else if (s1_inside_q)         rgb_d = fill_rgb;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_hcount_q    <= '0;
            s1_vcount_q    <= '0;
            s1_hsync_q     <= 1'b0;
            s1_vsync_q     <= 1'b0;
            s1_hblnk_q     <= 1'b0;
            s1_vblnk_q     <= 1'b0;
            s1_rgb_q       <= '0;
            s1_inside_q    <= 1'b0;
            vga_out_hcount <= '0;
            vga_out_vcount <= '0;
            vga_out_hsync  <= 1'b0;
            vga_out_vsync  <= 1'b0;
            vga_out_hblnk  <= 1'b0;
            vga_out_vblnk  <= 1'b0;
            vga_out_rgb    <= '0;
        end else begin
            s1_hcount_q    <= vga_in_hcount;
            s1_vcount_q    <= vga_in_vcount;
            s1_hsync_q     <= vga_in_hsync;
            s1_vsync_q     <= vga_in_vsync;
            s1_hblnk_q     <= vga_in_hblnk;
            s1_vblnk_q     <= vga_in_vblnk;
            s1_rgb_q       <= vga_in_rgb;
            s1_inside_q    <= inside_c;
            vga_out_hcount <= s1_hcount_q;
            vga_out_vcount <= s1_vcount_q;
            vga_out_hsync  <= s1_hsync_q;
            vga_out_vsync  <= s1_vsync_q;
            vga_out_hblnk  <= s1_hblnk_q;
            vga_out_vblnk  <= s1_vblnk_q;
            vga_out_rgb    <= rgb_d;
        end
    end

endmodule
